vending_ctrl: RTL and testbench
===============================

Name: vending_ctrl

Overview:
Sequencing controller for the vending machine credit datapath. One shared 4-bit ripple adder (adder_4bit) does three jobs: accumulate inserted coins, deduct the price, and count change down one unit at a time. The block decides which operation the adder performs each cycle, drives the product-dispense handshake, and emits change/refund pulses. It sits between the coin acceptor front end and the dispense/change actuators.

Parameters:
PRICE, 4'd12, product price in credit units; legal range 1..15
VAL_A, 4'd1, credit value of coin code 2'b01
VAL_B, 4'd2, credit value of coin code 2'b10
VAL_C, 4'd5, credit value of coin code 2'b11

Ports:
i_clk  input  1  system clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_coin_valid  input  1  one-cycle strobe; coin present on i_coin_sel
i_coin_sel  input  2  coin code: 00 invalid, 01 A, 10 B, 11 C
i_cancel  input  1  one-cycle strobe; refund the current credit
i_dispense_ack  input  1  dispenser has taken the product
o_dispense  output  1  product request; held high until acknowledged
o_change_pulse  output  1  one pulse per returned credit unit
o_coin_reject  output  1  one-cycle pulse; the coin was not credited
o_credit  output  4  current credit register
o_busy  output  1  high in VEND or CHANGE

Behaviour:
- Reset: asynchronous. All outputs go to 0, state goes to IDLE and credit to 0 immediately. Any credit held when reset asserts is lost.
- States:
  - IDLE: credit == 0.
  - COLLECT: 0 < credit < PRICE.
  - VEND: dispense handshake in progress.
  - CHANGE: returning credit one unit per cycle.
- Adder operand mux (cin shown last):
  - IDLE/COLLECT: credit + coin value, cin 0.
  - VEND: credit + ~PRICE, cin 1.
  - CHANGE: credit + 4'hF, cin 0 (credit - 1).
- Coin acceptance (IDLE/COLLECT only):
  - Coin accepted when i_coin_valid=1, i_coin_sel≠00, adder cout=0, and i_cancel=0.
  - On acceptance, credit takes the adder sum at the next edge.
  - If sum ≥ PRICE, go to VEND; otherwise go to COLLECT.
  - Latency: strobe in cycle N → o_credit updated and o_dispense high in cycle N+1.
- Coin rejection:
  - Cases: code 00, adder overflow (cout=1), state VEND or CHANGE, or simultaneous i_cancel.
  - Response: o_coin_reject=1 in cycle N+1; credit and state unchanged.
- VEND:
  - o_dispense=1 and held while i_dispense_ack=0.
  - On the ack cycle, credit takes credit - PRICE.
  - Next state is CHANGE if the remainder ≠ 0, else IDLE.
  - o_dispense drops the cycle after ack.
  - i_cancel is ignored in VEND.
- CHANGE:
  - o_change_pulse=1 every cycle in this state (Moore output); credit decrements by 1 per cycle.
  - Leave for IDLE at the edge where credit goes 1→0, so the number of pulses equals the credit on entry.
  - i_cancel is ignored in CHANGE.
- Cancel: i_cancel in COLLECT goes to CHANGE with credit unchanged. In IDLE it is a no-op. Cancel takes priority over a simultaneous coin, and that coin is rejected.
- Sum exactly equal to PRICE: VEND, then IDLE after ack, with no change pulses.
- o_busy = (state==VEND) or (state==CHANGE).
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- The adder cout is used only for overflow detection in IDLE/COLLECT. In VEND and CHANGE it is ignored because wrap is intended.

Decomposition:
- Package vending_pkg holds:
  - state enum: IDLE, COLLECT, VEND, CHANGE, 2-bit encoding;
  - coin code constants: COIN_NONE, COIN_A, COIN_B, COIN_C;
  - adder-op enum: OP_ADD_COIN, OP_SUB_PRICE, OP_DEC.
- Sub-module: a single adder_4bit instance driven by the operand mux. No other sub-modules.
- Remaining logic (FSM, coin decode, output registers) stays in vending_ctrl.

Test Plan:
1. PRICE=12; coins C, C, B. Required: o_credit 5→10→12; o_dispense high the cycle after B. Ack 2 cycles later → IDLE, credit 0, zero change pulses.
2. PRICE=12; coins C, C, C. Required: credit 15, VEND. On ack, credit 3, then exactly 3 o_change_pulse cycles with credit 3→2→1, then IDLE with credit 0.
3. PRICE=15; reach credit 14 (C, C, B, B), then coin C. Required: overflow, o_coin_reject pulse, credit stays 14, state COLLECT. Code 00 also gives a reject.
4. Credit 7, i_cancel asserted together with a coin B. Required: coin rejected, 7 change pulses, o_busy=1 throughout. A coin inserted during CHANGE is rejected and the pulse count is unchanged.
5. Coin inserted while o_dispense=1 and ack withheld 5 cycles. Required: reject pulse; o_dispense stays high and credit is unchanged until ack.
6. Assert i_rst mid-CHANGE at credit 2, asynchronously between clock edges. Required: o_change_pulse, o_busy and o_credit go to 0 immediately. After release the block is IDLE and accepts a coin A → credit 1.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending credit controller.
package vending_pkg;

  localparam int unsigned CREDIT_W = 4;
  localparam int unsigned COIN_W   = 2;

  // Controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_e;

  // Coin acceptor codes
  localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
  localparam logic [COIN_W-1:0] COIN_A    = 2'b01;
  localparam logic [COIN_W-1:0] COIN_B    = 2'b10;
  localparam logic [COIN_W-1:0] COIN_C    = 2'b11;

  // Operation selected for the shared adder
  typedef enum logic [1:0] {
    OP_ADD_COIN  = 2'd0,
    OP_SUB_PRICE = 2'd1,
    OP_DEC       = 2'd2
  } adder_op_e;

  // Operand bundle presented to the shared adder
  typedef struct packed {
    logic [CREDIT_W-1:0] a;
    logic [CREDIT_W-1:0] b;
    logic                cin;
  } adder_in_t;

  // Build adder operands: add coin, subtract price (two's complement), or decrement
  function automatic adder_in_t adder_operands(input adder_op_e           op,
                                               input logic [CREDIT_W-1:0] credit,
                                               input logic [CREDIT_W-1:0] coin_val,
                                               input logic [CREDIT_W-1:0] price);
    adder_in_t r;
    r.a   = credit;
    r.b   = coin_val;
    r.cin = 1'b0;
    case (op)
      OP_SUB_PRICE: begin
        r.b   = ~price;
        r.cin = 1'b1;
      end
      OP_DEC: begin
        r.b   = {CREDIT_W{1'b1}};
        r.cin = 1'b0;
      end
      default: begin
        r.b   = coin_val;
        r.cin = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple-carry adder shared by the credit datapath.
module adder_4bit
  import vending_pkg::*;
(
  input  logic [CREDIT_W-1:0] a,
  input  logic [CREDIT_W-1:0] b,
  input  logic                cin,
  output logic [CREDIT_W-1:0] sum,
  output logic                cout
);

  logic [CREDIT_W:0] carry;

  assign carry[0] = cin;

  // Full-adder chain, carry ripples from bit 0 upward
  for (genvar i = 0; i < CREDIT_W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[CREDIT_W];

endmodule

// File: rtl/vending_ctrl.sv
// Vending machine credit sequencer: coin accumulation, price deduction and change return
// through one shared adder, with dispense handshake and change/reject pulses.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter logic [CREDIT_W-1:0] PRICE = 4'd12,
  parameter logic [CREDIT_W-1:0] VAL_A = 4'd1,
  parameter logic [CREDIT_W-1:0] VAL_B = 4'd2,
  parameter logic [CREDIT_W-1:0] VAL_C = 4'd5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_coin_valid,
  input  logic [COIN_W-1:0]   i_coin_sel,
  input  logic                i_cancel,
  input  logic                i_dispense_ack,
  output logic                o_dispense,
  output logic                o_change_pulse,
  output logic                o_coin_reject,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy
);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_d, change_d, reject_d, busy_d;

  adder_op_e           op;
  adder_in_t           add_in;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic                cout;

  // Coin code to credit value; invalid code contributes nothing
  always_comb begin
    coin_val = '0;
    case (i_coin_sel)
      COIN_A:  coin_val = VAL_A;
      COIN_B:  coin_val = VAL_B;
      COIN_C:  coin_val = VAL_C;
      default: coin_val = '0;
    endcase
  end

  // Adder operation follows the current state
  always_comb begin
    op = OP_ADD_COIN;
    case (state_q)
      VEND:    op = OP_SUB_PRICE;
      CHANGE:  op = OP_DEC;
      default: op = OP_ADD_COIN;
    endcase
  end

  assign add_in = adder_operands(op, credit_q, coin_val, PRICE);

  adder_4bit u_adder (
    .a    (add_in.a),
    .b    (add_in.b),
    .cin  (add_in.cin),
    .sum  (sum),
    .cout (cout)
  );

  // Next state, next credit and next registered outputs
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        if (i_cancel) begin
          // Cancel wins over a simultaneous coin; empty credit means nothing to refund
          reject_d = i_coin_valid;
          if (state_q == COLLECT) begin
            state_d = CHANGE;
          end
        end else if (i_coin_valid) begin
          if ((i_coin_sel == COIN_NONE) || cout) begin
            reject_d = 1'b1;
          end else begin
            credit_d = sum;
            state_d  = (sum >= PRICE) ? VEND : COLLECT;
          end
        end
      end
      VEND: begin
        reject_d = i_coin_valid;
        if (i_dispense_ack) begin
          credit_d = sum;
          state_d  = (sum != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        reject_d = i_coin_valid;
        credit_d = sum;
        if (credit_q == CREDIT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase

    dispense_d = (state_d == VEND);
    change_d   = (state_d == CHANGE);
    busy_d     = dispense_d | change_d;
  end

  // State, credit and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      o_dispense     <= 1'b0;
      o_change_pulse <= 1'b0;
      o_coin_reject  <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      o_dispense     <= dispense_d;
      o_change_pulse <= change_d;
      o_coin_reject  <= reject_d;
      o_busy         <= busy_d;
    end
  end

  assign o_credit = credit_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Bench for vending_ctrl: directed scenarios plus random traffic against a credit-level model.
module tb_vending_ctrl;

  localparam int PRICE = 12;

  logic       i_clk;
  logic       i_rst;
  logic       i_coin_valid;
  logic [1:0] i_coin_sel;
  logic       i_cancel;
  logic       i_dispense_ack;
  logic       o_dispense;
  logic       o_change_pulse;
  logic       o_coin_reject;
  logic [3:0] o_credit;
  logic       o_busy;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // Reference model: credit held as an integer plus two activity flags
  int m_credit;
  bit m_vending;
  bit m_refunding;
  bit m_reject;

  vending_ctrl #(
    .PRICE (4'd12),
    .VAL_A (4'd1),
    .VAL_B (4'd2),
    .VAL_C (4'd5)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_coin_valid   (i_coin_valid),
    .i_coin_sel     (i_coin_sel),
    .i_cancel       (i_cancel),
    .i_dispense_ack (i_dispense_ack),
    .o_dispense     (o_dispense),
    .o_change_pulse (o_change_pulse),
    .o_coin_reject  (o_coin_reject),
    .o_credit       (o_credit),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic int coin_value(input logic [1:0] sel);
    case (sel)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit    = 0;
    m_vending   = 0;
    m_refunding = 0;
    m_reject    = 0;
  endtask

  // Advance the model by one clock using the currently applied inputs
  task automatic model_step();
    int v;
    v = coin_value(i_coin_sel);
    m_reject = 0;
    if (m_vending) begin
      if (i_coin_valid) m_reject = 1;
      if (i_dispense_ack) begin
        m_credit    = m_credit - PRICE;
        m_vending   = 0;
        m_refunding = (m_credit > 0);
      end
    end else if (m_refunding) begin
      if (i_coin_valid) m_reject = 1;
      m_credit = m_credit - 1;
      if (m_credit == 0) m_refunding = 0;
    end else if (i_cancel) begin
      if (i_coin_valid) m_reject = 1;
      if (m_credit > 0) m_refunding = 1;
    end else if (i_coin_valid) begin
      if (i_coin_sel == 2'b00 || m_credit + v > 15) begin
        m_reject = 1;
      end else begin
        m_credit = m_credit + v;
        if (m_credit >= PRICE) m_vending = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".credit"},   o_credit,       4'(m_credit));
    check({tag, ".dispense"}, o_dispense,     4'(m_vending));
    check({tag, ".change"},   o_change_pulse, 4'(m_refunding));
    check({tag, ".reject"},   o_coin_reject,  4'(m_reject));
    check({tag, ".busy"},     o_busy,         4'(m_vending | m_refunding));
  endtask

  // One clock: sample #1 after the edge, advance the model, compare everything
  task automatic cycle(input string tag);
    @(posedge i_clk);
    #1;
    model_step();
    compare_all(tag);
    if (o_change_pulse) pulses++;
  endtask

  task automatic coin(input logic [1:0] sel, input string tag);
    i_coin_valid = 1'b1;
    i_coin_sel   = sel;
    cycle(tag);
    i_coin_valid = 1'b0;
    i_coin_sel   = 2'b00;
  endtask

  task automatic ack(input string tag);
    i_dispense_ack = 1'b1;
    cycle(tag);
    i_dispense_ack = 1'b0;
  endtask

  // Run until idle with a cycle budget; expiry is a failed comparison
  task automatic drain(input int max, input string tag);
    for (int k = 0; k < max && o_busy; k++) cycle(tag);
    check({tag, ".drained"}, o_busy, 4'd0);
  endtask

  initial begin
    i_clk = 0; i_rst = 0;
    i_coin_valid = 0; i_coin_sel = 0; i_cancel = 0; i_dispense_ack = 0;
    model_reset();
    #1 i_rst = 1;
    #2;
    compare_all("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 0;

    // 1: exact price, no change
    coin(2'b11, "t1c1"); check("t1.credit5", o_credit, 4'd5);
    coin(2'b11, "t1c2"); check("t1.credit10", o_credit, 4'd10);
    coin(2'b10, "t1c3"); check("t1.credit12", o_credit, 4'd12);
    check("t1.dispense", o_dispense, 4'd1);
    pulses = 0;
    cycle("t1w"); cycle("t1w");
    ack("t1ack");
    cycle("t1post");
    check("t1.idle_credit", o_credit, 4'd0);
    check("t1.no_pulses", 4'(pulses), 4'd0);

    // 2: overpay by 3, three change pulses
    coin(2'b11, "t2"); coin(2'b11, "t2"); coin(2'b11, "t2");
    check("t2.credit15", o_credit, 4'd15);
    pulses = 0;
    ack("t2ack");
    check("t2.after_ack", o_credit, 4'd3);
    drain(10, "t2d");
    check("t2.pulses", 4'(pulses), 4'd3);
    check("t2.final_credit", o_credit, 4'd0);

    // 3: overflow reject at credit 11, invalid code reject, then cancel
    coin(2'b11, "t3"); coin(2'b11, "t3"); coin(2'b01, "t3");
    coin(2'b11, "t3ovf");
    check("t3.ovf_reject", o_coin_reject, 4'd1);
    check("t3.ovf_credit", o_credit, 4'd11);
    coin(2'b00, "t3none");
    check("t3.none_reject", o_coin_reject, 4'd1);
    i_cancel = 1; cycle("t3cancel"); i_cancel = 0;
    drain(20, "t3d");

    // 4: cancel with simultaneous coin, coin during change
    coin(2'b11, "t4"); coin(2'b10, "t4");
    check("t4.credit7", o_credit, 4'd7);
    pulses = 0;
    i_cancel = 1; i_coin_valid = 1; i_coin_sel = 2'b10;
    cycle("t4cancel");
    i_cancel = 0; i_coin_valid = 0; i_coin_sel = 2'b00;
    check("t4.cancel_reject", o_coin_reject, 4'd1);
    check("t4.busy", o_busy, 4'd1);
    cycle("t4p"); cycle("t4p");
    coin(2'b01, "t4coin");
    check("t4.change_reject", o_coin_reject, 4'd1);
    drain(20, "t4d");
    check("t4.pulses", 4'(pulses), 4'd7);

    // 5: coin during dispense, ack withheld
    coin(2'b11, "t5"); coin(2'b11, "t5"); coin(2'b10, "t5");
    coin(2'b01, "t5coin");
    check("t5.reject", o_coin_reject, 4'd1);
    for (int k = 0; k < 4; k++) cycle("t5hold");
    check("t5.held", o_dispense, 4'd1);
    check("t5.credit", o_credit, 4'd12);
    ack("t5ack");
    cycle("t5post");
    check("t5.dropped", o_dispense, 4'd0);

    // 6: asynchronous reset mid-change at credit 2
    coin(2'b11, "t6"); coin(2'b11, "t6"); coin(2'b11, "t6");
    ack("t6ack");
    cycle("t6p");
    check("t6.credit2", o_credit, 4'd2);
    #2 i_rst = 1;
    #1;
    model_reset();
    check("t6.rst_pulse", o_change_pulse, 4'd0);
    check("t6.rst_busy", o_busy, 4'd0);
    check("t6.rst_credit", o_credit, 4'd0);
    #3 i_rst = 0;
    coin(2'b01, "t6a");
    check("t6.credit1", o_credit, 4'd1);
    i_cancel = 1; cycle("t6cancel"); i_cancel = 0;
    drain(5, "t6d");

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      i_coin_valid   = ($urandom_range(0, 2) == 0);
      i_coin_sel     = 2'($urandom_range(0, 3));
      i_cancel       = ($urandom_range(0, 11) == 0);
      i_dispense_ack = m_vending ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      cycle("rand");
    end
    i_coin_valid = 0; i_cancel = 0; i_dispense_ack = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
